// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - shared timing presets and sync bundle type for the video timing generator
package video_timing_pkg;

  // 1280x720 @ 60 Hz (74.25 MHz pixel clock)
  localparam int V720_ACTIVE_H = 1280;
  localparam int V720_FP_H     = 110;
  localparam int V720_SYNC_H   = 40;
  localparam int V720_BP_H     = 220;
  localparam int V720_ACTIVE_V = 720;
  localparam int V720_FP_V     = 5;
  localparam int V720_SYNC_V   = 5;
  localparam int V720_BP_V     = 20;

  // 640x480 @ 60 Hz (25.175 MHz pixel clock)
  localparam int V480_ACTIVE_H = 640;
  localparam int V480_FP_H     = 16;
  localparam int V480_SYNC_H   = 96;
  localparam int V480_BP_H     = 48;
  localparam int V480_ACTIVE_V = 480;
  localparam int V480_FP_V     = 10;
  localparam int V480_SYNC_V   = 2;
  localparam int V480_BP_V     = 33;

  // Signals that travel together through the alignment delay line
  typedef struct packed {
    logic hs;
    logic vs;
    logic ad;
  } sync_bits_t;

endpackage

// File: rtl/sig_delay.sv
// rtl/sig_delay.sv - synchronous-reset shift register, DEPTH=0 is a wire
module sig_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk_pixel_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  generate
    if (DEPTH == 0) begin : g_pass
      wire unused_pass = &{1'b0, clk_pixel_in, rst_in};
      assign data_out = data_in;
    end else begin : g_shift
      logic [WIDTH-1:0] stage_q [DEPTH];

      // Shift one stage per pixel; reset clears every stage so no stale sync escapes
      always_ff @(posedge clk_pixel_in) begin
        if (rst_in) begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
          stage_q[0] <= data_in;
          for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign data_out = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/video_timing_scaled.sv
// rtl/video_timing_scaled.sv - parametrised raster timing with scaled coordinates and aligned sync copies
module video_timing_scaled
  import video_timing_pkg::*;
#(
  parameter int ACTIVE_H    = V720_ACTIVE_H,
  parameter int FP_H        = V720_FP_H,
  parameter int SYNC_H      = V720_SYNC_H,
  parameter int BP_H        = V720_BP_H,
  parameter int ACTIVE_V    = V720_ACTIVE_V,
  parameter int FP_V        = V720_FP_V,
  parameter int SYNC_V      = V720_SYNC_V,
  parameter int BP_V        = V720_BP_V,
  parameter int SCALE_SHIFT = 2,
  parameter int PIPE_DELAY  = 4,
  parameter int FC_WRAP     = 60,
  localparam int H_TOTAL    = ACTIVE_H + FP_H + SYNC_H + BP_H,
  localparam int V_TOTAL    = ACTIVE_V + FP_V + SYNC_V + BP_V,
  localparam int HW         = $clog2(H_TOTAL),
  localparam int VW         = $clog2(V_TOTAL),
  localparam int FW         = $clog2(FC_WRAP)
) (
  input  logic                   clk_pixel_in,
  input  logic                   rst_in,
  output logic [HW-1:0]          hcount_out,
  output logic [VW-1:0]          vcount_out,
  output logic                   hs_out,
  output logic                   vs_out,
  output logic                   ad_out,
  output logic                   nf_out,
  output logic [FW-1:0]          fc_out,
  output logic [HW-SCALE_SHIFT-1:0] sx_out,
  output logic [VW-SCALE_SHIFT-1:0] sy_out,
  output logic                   pix_req_out,
  output logic                   hs_d_out,
  output logic                   vs_d_out,
  output logic                   ad_d_out
);

  if (SYNC_H <= 0) begin : g_chk_sync_h
    $error("SYNC_H must be greater than zero");
  end
  if (SYNC_V <= 0) begin : g_chk_sync_v
    $error("SYNC_V must be greater than zero");
  end
  if (SCALE_SHIFT < 0 || SCALE_SHIFT > 4) begin : g_chk_shift
    $error("SCALE_SHIFT must be in 0..4");
  end
  if ((ACTIVE_H % (1 << SCALE_SHIFT)) != 0 || (ACTIVE_V % (1 << SCALE_SHIFT)) != 0) begin : g_chk_div
    $error("ACTIVE_H and ACTIVE_V must be divisible by 2**SCALE_SHIFT");
  end
  if (FC_WRAP < 2) begin : g_chk_fc
    $error("FC_WRAP must be at least 2");
  end
  if (PIPE_DELAY < 0 || PIPE_DELAY > 31) begin : g_chk_delay
    $error("PIPE_DELAY must be in 0..31");
  end

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(ACTIVE_H);
  localparam logic [VW-1:0] V_ACT  = VW'(ACTIVE_V);
  localparam logic [HW-1:0] H_SS   = HW'(ACTIVE_H + FP_H);
  localparam logic [HW:0]   H_SE   = (HW+1)'(ACTIVE_H + FP_H + SYNC_H);
  localparam logic [VW-1:0] V_SS   = VW'(ACTIVE_V + FP_V);
  localparam logic [VW:0]   V_SE   = (VW+1)'(ACTIVE_V + FP_V + SYNC_V);
  localparam logic [HW-1:0] H_MASK = HW'((1 << SCALE_SHIFT) - 1);
  localparam logic [VW-1:0] V_MASK = VW'((1 << SCALE_SHIFT) - 1);
  localparam logic [FW-1:0] FC_LAST = FW'(FC_WRAP - 1);

  logic          started_q;
  logic [HW-1:0] h_q, h_nx;
  logic [VW-1:0] v_q, v_nx;
  logic          hs_q, vs_q, ad_q, nf_q, pix_q;
  logic          ad_nx, nf_nx;
  logic [FW-1:0] fc_q;

  // Next raster position; the first cycle out of reset presents (0,0) rather than advancing past it
  always_comb begin
    h_nx = h_q + 1'b1;
    v_nx = v_q;
    if (!started_q) begin
      h_nx = '0;
      v_nx = '0;
    end else if (h_q == H_LAST) begin
      h_nx = '0;
      v_nx = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end
    ad_nx = (h_nx < H_ACT) && (v_nx < V_ACT);
    nf_nx = (h_nx == H_ACT) && (v_nx == V_ACT);
  end

  // Counters and decodes register together from the next position, so they never skew
  always_ff @(posedge clk_pixel_in) begin
    if (rst_in) begin
      started_q <= 1'b0;
      h_q       <= '0;
      v_q       <= '0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      ad_q      <= 1'b0;
      nf_q      <= 1'b0;
      pix_q     <= 1'b0;
      fc_q      <= '0;
    end else begin
      started_q <= 1'b1;
      h_q       <= h_nx;
      v_q       <= v_nx;
      ad_q      <= ad_nx;
      hs_q      <= (h_nx >= H_SS) && ({1'b0, h_nx} < H_SE);
      vs_q      <= (v_nx >= V_SS) && ({1'b0, v_nx} < V_SE);
      nf_q      <= nf_nx;
      pix_q     <= ad_nx && ((h_nx & H_MASK) == '0) && ((v_nx & V_MASK) == '0);
      if (nf_nx) fc_q <= (fc_q == FC_LAST) ? '0 : fc_q + 1'b1;
    end
  end

  sync_bits_t now_bits, dly_bits;
  assign now_bits = {hs_q, vs_q, ad_q};

  sig_delay #(
    .WIDTH ($bits(sync_bits_t)),
    .DEPTH (PIPE_DELAY)
  ) u_sync_delay (
    .clk_pixel_in (clk_pixel_in),
    .rst_in       (rst_in),
    .data_in      (now_bits),
    .data_out     (dly_bits)
  );

  assign hcount_out  = h_q;
  assign vcount_out  = v_q;
  assign hs_out      = hs_q;
  assign vs_out      = vs_q;
  assign ad_out      = ad_q;
  assign nf_out      = nf_q;
  assign fc_out      = fc_q;
  assign sx_out      = h_q[HW-1:SCALE_SHIFT];
  assign sy_out      = v_q[VW-1:SCALE_SHIFT];
  assign pix_req_out = pix_q;
  assign hs_d_out    = dly_bits.hs;
  assign vs_d_out    = dly_bits.vs;
  assign ad_d_out    = dly_bits.ad;

endmodule

// File: tb/tb_video_timing_scaled.sv
// tb/tb_video_timing_scaled.sv - directed bench on a reduced 24x12 raster
module tb_video_timing_scaled;

  localparam int HT    = 24;
  localparam int VT    = 12;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [4:0] a_hcount, b_hcount;
  logic [3:0] a_vcount, b_vcount;
  logic       a_hs, a_vs, a_ad, a_nf, a_pix, a_hs_d, a_vs_d, a_ad_d;
  logic       b_hs, b_vs, b_ad, b_nf, b_pix, b_hs_d, b_vs_d, b_ad_d;
  logic [1:0] a_fc;
  logic [0:0] b_fc;
  logic [2:0] a_sx;
  logic [1:0] a_sy;
  logic [4:0] b_sx;
  logic [3:0] b_sy;

  video_timing_scaled #(
    .ACTIVE_H(16), .FP_H(2), .SYNC_H(3), .BP_H(3),
    .ACTIVE_V(8),  .FP_V(1), .SYNC_V(2), .BP_V(1),
    .SCALE_SHIFT(2), .PIPE_DELAY(4), .FC_WRAP(3)
  ) dut_a (
    .clk_pixel_in(clk), .rst_in(rst),
    .hcount_out(a_hcount), .vcount_out(a_vcount),
    .hs_out(a_hs), .vs_out(a_vs), .ad_out(a_ad), .nf_out(a_nf), .fc_out(a_fc),
    .sx_out(a_sx), .sy_out(a_sy), .pix_req_out(a_pix),
    .hs_d_out(a_hs_d), .vs_d_out(a_vs_d), .ad_d_out(a_ad_d)
  );

  video_timing_scaled #(
    .ACTIVE_H(16), .FP_H(2), .SYNC_H(3), .BP_H(3),
    .ACTIVE_V(8),  .FP_V(1), .SYNC_V(2), .BP_V(1),
    .SCALE_SHIFT(0), .PIPE_DELAY(0), .FC_WRAP(2)
  ) dut_b (
    .clk_pixel_in(clk), .rst_in(rst),
    .hcount_out(b_hcount), .vcount_out(b_vcount),
    .hs_out(b_hs), .vs_out(b_vs), .ad_out(b_ad), .nf_out(b_nf), .fc_out(b_fc),
    .sx_out(b_sx), .sy_out(b_sy), .pix_req_out(b_pix),
    .hs_d_out(b_hs_d), .vs_d_out(b_vs_d), .ad_d_out(b_ad_d)
  );

  int ha, va, hb, vb;
  assign ha = int'(a_hcount);
  assign va = int'(a_vcount);
  assign hb = int'(b_hcount);
  assign vb = int'(b_vcount);

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    logic [3:0] hh, vh, ah;
    int pos_bad, hs_bad, vs_bad, ad_bad, sc_bad, dly_bad, b_dly_bad, b_sc_bad;
    int n_hs, n_vs, n_ad, n_nf, n_pix_a, n_pix_b;
    pos_bad = 0; hs_bad = 0; vs_bad = 0; ad_bad = 0; sc_bad = 0; dly_bad = 0;
    b_dly_bad = 0; b_sc_bad = 0;
    n_hs = 0; n_vs = 0; n_ad = 0; n_nf = 0; n_pix_a = 0; n_pix_b = 0;
    hh = '0; vh = '0; ah = '0;

    rst = 1'b1;
    repeat (3) tick();
    chk("reset_h", ha, 0);
    chk("reset_v", va, 0);
    chk("reset_ad", int'(a_ad), 0);
    chk("reset_nf_pix", int'(a_nf | a_pix), 0);
    chk("reset_dly", int'({a_hs_d, a_vs_d, a_ad_d}), 0);
    chk("reset_b_ad_d", int'(b_ad_d), 0);

    rst = 1'b0;
    tick();
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < FRAME; i++) begin
        if (ha != i % HT || va != i / HT || hb != ha || vb != va) pos_bad++;
        if (a_hs !== (ha >= 18 && ha <= 20)) hs_bad++;
        if (a_vs !== (va >= 9 && va <= 10)) vs_bad++;
        if (a_ad !== (ha < 16 && va < 8)) ad_bad++;
        if (a_ad && (int'(a_sx) != ha / 4 || int'(a_sy) != va / 4)) sc_bad++;
        if (b_ad && (int'(b_sx) != hb || int'(b_sy) != vb)) b_sc_bad++;
        if (a_hs_d !== hh[3] || a_vs_d !== vh[3] || a_ad_d !== ah[3]) dly_bad++;
        if (b_hs_d !== b_hs || b_vs_d !== b_vs || b_ad_d !== b_ad) b_dly_bad++;
        n_hs    += int'(a_hs);
        n_vs    += int'(a_vs);
        n_ad    += int'(a_ad);
        n_nf    += int'(a_nf);
        n_pix_a += int'(a_pix);
        n_pix_b += int'(b_pix);

        if (f == 0) begin
          case (i)
            0: begin
              chk("first_h", ha, 0);
              chk("first_v", va, 0);
              chk("first_ad", int'(a_ad), 1);
              chk("first_pix", int'(a_pix), 1);
              chk("first_fc", int'(a_fc), 0);
              chk("first_ad_d", int'(a_ad_d), 0);
              chk("first_b_ad_d", int'(b_ad_d), 1);
            end
            1:   chk("pix_h1", int'(a_pix), 0);
            3:   chk("ad_d_before_rise", int'(a_ad_d), 0);
            4: begin
              chk("ad_d_rise", int'(a_ad_d), 1);
              chk("pix_h4", int'(a_pix), 1);
            end
            17:  chk("hs_h17", int'(a_hs), 0);
            18:  chk("hs_h18", int'(a_hs), 1);
            19:  chk("ad_d_before_fall", int'(a_ad_d), 1);
            20: begin
              chk("ad_d_fall", int'(a_ad_d), 0);
              chk("hs_h20", int'(a_hs), 1);
            end
            21:  chk("hs_h21", int'(a_hs), 0);
            24: begin
              chk("line1_ad", int'(a_ad), 1);
              chk("line1_pix", int'(a_pix), 0);
              chk("line_wrap_v", va, 1);
            end
            96: begin
              chk("row4_h", ha, 0);
              chk("row4_v", va, 4);
              chk("row4_pix", int'(a_pix), 1);
            end
            157: begin
              chk("sx_13", int'(a_sx), 3);
              chk("sy_6", int'(a_sy), 1);
            end
            207: begin
              chk("pre_nf", int'(a_nf), 0);
              chk("pre_nf_fc", int'(a_fc), 0);
            end
            208: begin
              chk("nf_pulse", int'(a_nf), 1);
              chk("nf_fc", int'(a_fc), 1);
              chk("nf_pos_h", ha, 16);
            end
            209: chk("nf_one_cycle", int'(a_nf), 0);
            215: chk("vs_v8", int'(a_vs), 0);
            216: chk("vs_v9", int'(a_vs), 1);
            263: chk("vs_v10_end", int'(a_vs), 1);
            264: chk("vs_v11", int'(a_vs), 0);
            287: begin
              chk("last_h", ha, 23);
              chk("last_v", va, 11);
            end
            default: ;
          endcase
        end
        if (f == 1 && i == 0) chk("fc_frame1", int'(a_fc), 1);
        if (f == 2 && i == 0) chk("fc_frame2", int'(a_fc), 2);

        hh = {hh[2:0], a_hs};
        vh = {vh[2:0], a_vs};
        ah = {ah[2:0], a_ad};
        tick();
      end
    end

    chk("frame_wrap_h", ha, 0);
    chk("frame_wrap_v", va, 0);
    chk("fc_wrap", int'(a_fc), 0);
    chk("pos_bad", pos_bad, 0);
    chk("hs_bad", hs_bad, 0);
    chk("vs_bad", vs_bad, 0);
    chk("ad_bad", ad_bad, 0);
    chk("scale_bad", sc_bad, 0);
    chk("b_scale_bad", b_sc_bad, 0);
    chk("delay_bad", dly_bad, 0);
    chk("b_delay_bad", b_dly_bad, 0);
    chk("n_hs", n_hs, 108);
    chk("n_vs", n_vs, 144);
    chk("n_ad", n_ad, 384);
    chk("n_nf", n_nf, 3);
    chk("n_pix_a", n_pix_a, 24);
    chk("n_pix_b", n_pix_b, 384);

    repeat (230) tick();
    chk("mid_h", ha, 14);
    chk("mid_v", va, 9);
    chk("mid_fc", int'(a_fc), 1);
    rst = 1'b1;
    repeat (3) tick();
    chk("mid_rst_h", ha, 0);
    chk("mid_rst_ad", int'(a_ad), 0);
    chk("mid_rst_fc", int'(a_fc), 0);
    rst = 1'b0;
    tick();
    chk("restart_h", ha, 0);
    chk("restart_v", va, 0);
    chk("restart_fc", int'(a_fc), 0);
    chk("restart_ad", int'(a_ad), 1);
    for (int j = 0; j < 4; j++) begin
      chk("restart_dly_low", int'({a_hs_d, a_vs_d, a_ad_d}), 0);
      tick();
    end
    chk("restart_ad_d_rise", int'(a_ad_d), 1);
    chk("restart_rise_h", ha, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
